// File: rtl/verify_mipi_transmitter.sv
// verify_mipi_transmitter: frames one DLEN-byte payload onto a 48-bit link as SOF, header, NW data words and a pad word.
module verify_mipi_transmitter #(
    parameter int          DLEN     = 6,
    parameter logic [23:0] SOF      = 24'hEAFF99,
    parameter int          IDLE_GAP = 1
) (
    input  logic              tx_pixel_clk,
    input  logic              rst,
    input  logic [DLEN*8-1:0] data,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [23:0]       pkt_id,
    input  logic [7:0]        dtype,
    input  logic [7:0]        phl_id,
    output logic [47:0]       packet,
    output logic              packet_valid,
    output logic              transmitting
);
    localparam int NW = (DLEN + 5) / 6;
    localparam int PW = NW * 48;
    localparam int CW = $clog2(NW + 1);
    localparam int GW = IDLE_GAP > 0 ? $clog2(IDLE_GAP + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SOF, S_HDR, S_DATA, S_PAD, S_GAP} state_t;

    state_t            state, state_n;
    logic [DLEN*8-1:0] data_r;
    logic [23:0]       id_r;
    logic [7:0]        dtype_r, phl_r;
    logic [CW-1:0]     cnt;
    logic [GW-1:0]     gap;
    logic [PW-1:0]     p;
    logic [47:0]       c;

    assign p = PW'(data_r);
    // most significant 48-bit chunk goes out first
    assign c = 48'(p >> (48 * (NW - 1 - int'(cnt))));
    assign data_ready = state == S_IDLE && !rst;
    assign transmitting = packet_valid;

    always_ff @(posedge tx_pixel_clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt <= '0;
            gap <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && data_valid) begin
                data_r <= data;
                id_r <= pkt_id;
                dtype_r <= dtype;
                phl_r <= phl_id;
            end
            cnt <= state == S_SOF ? '0 : state == S_DATA ? cnt + 1'b1 : cnt;
            gap <= state == S_PAD ? GW'(IDLE_GAP) : state == S_GAP ? gap - 1'b1 : gap;
        end
    end

    always_comb begin
        state_n = state;
        packet = '0;
        packet_valid = 1'b0;
        case (state)
            S_IDLE: if (data_valid) state_n = S_SOF;
            S_SOF: begin
                state_n = S_HDR;
                packet = {SOF, id_r};
                packet_valid = 1'b1;
            end
            S_HDR: begin
                state_n = S_DATA;
                packet = {dtype_r, 32'(DLEN), phl_r};
                packet_valid = 1'b1;
            end
            S_DATA: begin
                if (cnt == CW'(NW - 1)) state_n = S_PAD;
                packet = {c[23:0], c[47:24]};
                packet_valid = 1'b1;
            end
            S_PAD: begin
                state_n = S_IDLE;
                if (IDLE_GAP > 0) state_n = S_GAP;
                packet_valid = 1'b1;
            end
            S_GAP: if (gap == GW'(1)) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (rst) begin
            packet = '0;
            packet_valid = 1'b0;
        end
    end
endmodule

// File: tb/tb_verify_mipi_transmitter.sv
// tb_verify_mipi_transmitter: scoreboard and receive-parser bench across several DLEN/IDLE_GAP configurations.
module tb_verify_mipi_transmitter;
    localparam int NI = 7;
    localparam int DLS [NI] = '{6, 12, 8, 1, 5, 7, 18};
    localparam int GPS [NI] = '{1, 0, 2, 1, 0, 1, 3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [143:0] din [NI];
    logic dv [NI];
    logic dr [NI];
    logic pv [NI];
    logic tx [NI];
    logic [47:0] pkt [NI];
    logic [23:0] pid [NI];
    logic [7:0] dt [NI];
    logic [7:0] ph [NI];

    logic [47:0] q [NI][$];
    logic [183:0] rq [NI][$];
    int rw [NI];
    logic [143:0] acc [NI];
    logic [23:0] rid [NI];
    logic [7:0] rdt [NI];
    logic [7:0] rph [NI];
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    for (genvar g = 0; g < NI; g++) begin : gi
        verify_mipi_transmitter #(.DLEN(DLS[g]), .IDLE_GAP(GPS[g])) dut (
            .tx_pixel_clk(clk),
            .rst(rst),
            .data(din[g][DLS[g]*8-1:0]),
            .data_valid(dv[g]),
            .data_ready(dr[g]),
            .pkt_id(pid[g]),
            .dtype(dt[g]),
            .phl_id(ph[g]),
            .packet(pkt[g]),
            .packet_valid(pv[g]),
            .transmitting(tx[g])
        );
    end

    function automatic logic [143:0] msk(input int dl);
        return (144'b1 << (dl * 8)) - 144'b1;
    endfunction

    // byte-stream model: left-pad with zero bytes to whole 6-byte words, then half-swap each word
    function automatic void expect_frame(input int g, input logic [143:0] d, input logic [23:0] id,
                                         input logic [7:0] t, input logic [7:0] p);
        int dl;
        int nw;
        logic [7:0] s [$];
        dl = DLS[g];
        nw = (dl + 5) / 6;
        q[g].push_back({24'hEAFF99, id});
        q[g].push_back({t, 32'(dl), p});
        for (int i = 0; i < nw * 6 - dl; i++) s.push_back(8'h00);
        for (int i = dl - 1; i >= 0; i--) s.push_back(d[i*8 +: 8]);
        for (int w = 0; w < nw; w++)
            q[g].push_back({s[6*w+3], s[6*w+4], s[6*w+5], s[6*w], s[6*w+1], s[6*w+2]});
        q[g].push_back(48'h0);
        rq[g].push_back({d, id, t, p});
    endfunction

    task automatic scoreboard();
        logic [47:0] e;
        logic [183:0] t;
        int dl;
        int nw;
        forever begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                if (rst) rw[g] = 0;
                else begin
                    dl = DLS[g];
                    nw = (dl + 5) / 6;
                    checks++;
                    if (tx[g] !== pv[g] || (pv[g] !== 1'b1 && pkt[g] !== 48'h0)) begin
                        errors++;
                        $display("FAIL idle_tx inst=%0d pv=%b tx=%b packet=%h required tx=pv and packet=0 when idle",
                                 g, pv[g], tx[g], pkt[g]);
                    end
                    if (pv[g] === 1'b1) begin
                        checks++;
                        if (q[g].size() == 0) begin
                            errors++;
                            $display("FAIL spurious_word inst=%0d packet=%h required no valid word", g, pkt[g]);
                        end else begin
                            e = q[g].pop_front();
                            if (pkt[g] !== e) begin
                                errors++;
                                $display("FAIL word inst=%0d packet=%h required %h", g, pkt[g], e);
                            end
                        end
                        if (rw[g] == 0) begin
                            checks++;
                            if (pkt[g][47:24] !== 24'hEAFF99) begin
                                errors++;
                                $display("FAIL rx_sof inst=%0d marker=%h required eaff99", g, pkt[g][47:24]);
                            end
                            rid[g] = pkt[g][23:0];
                            acc[g] = '0;
                        end else if (rw[g] == 1) begin
                            rdt[g] = pkt[g][47:40];
                            rph[g] = pkt[g][7:0];
                            checks++;
                            if (pkt[g][39:8] !== 32'(dl)) begin
                                errors++;
                                $display("FAIL rx_dlen inst=%0d dlen=%h required %0d", g, pkt[g][39:8], dl);
                            end
                        end else if (rw[g] <= nw + 1) begin
                            acc[g] = {acc[g][95:0], pkt[g][23:0], pkt[g][47:24]};
                        end else begin
                            checks++;
                            if (rq[g].size() == 0) begin
                                errors++;
                                $display("FAIL rx_extra inst=%0d got frame required none", g);
                            end else begin
                                t = rq[g].pop_front();
                                if ({acc[g] & msk(dl), rid[g], rdt[g], rph[g]} !== t) begin
                                    errors++;
                                    $display("FAIL rx_payload inst=%0d got %h required %h", g,
                                             {acc[g] & msk(dl), rid[g], rdt[g], rph[g]}, t);
                                end
                            end
                        end
                        rw[g] = rw[g] == nw + 2 ? 0 : rw[g] + 1;
                    end
                end
            end
        end
    endtask

    task automatic send(input int g, input logic [143:0] d, input logic [23:0] id,
                        input logic [7:0] t, input logic [7:0] p, input bit hold);
        int n;
        n = 0;
        din[g] = d & msk(DLS[g]);
        pid[g] = id;
        dt[g] = t;
        ph[g] = p;
        dv[g] = 1'b1;
        while (dr[g] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dr[g] !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout inst=%0d data_ready=%b required 1", g, dr[g]);
        end else expect_frame(g, d & msk(DLS[g]), id, t, p);
        @(negedge clk);
        if (!hold) dv[g] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            checks++;
            if (dr[g] !== 1'b0 || pv[g] !== 1'b0 || tx[g] !== 1'b0 || pkt[g] !== 48'h0) begin
                errors++;
                $display("FAIL reset_state inst=%0d ready=%b pv=%b tx=%b packet=%h required all zero",
                         g, dr[g], pv[g], tx[g], pkt[g]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            checks++;
            if (dr[g] !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_reset inst=%0d ready=%b required 1", g, dr[g]);
            end
        end
    endtask

    task automatic test_frame_dlen6();
        logic [47:0] w [4];
        w = '{48'hEAFF99000001, 48'h2A0000000607, 48'h445566112233, 48'h000000000000};
        send(0, 144'h112233445566, 24'h000001, 8'h2A, 8'h07, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (pkt[0] !== w[k] || pv[0] !== 1'b1) begin
                errors++;
                $display("FAIL frame6_word%0d packet=%h pv=%b required %h pv=1", k, pkt[0], pv[0], w[k]);
            end
            @(negedge clk);
        end
        checks++;
        if (pv[0] !== 1'b0) begin
            errors++;
            $display("FAIL frame6_end pv=%b required 0", pv[0]);
        end
    endtask

    task automatic test_dlen12_nogap();
        logic [47:0] w [5];
        w = '{{24'hEAFF99, 24'h00ABCD}, {8'h12, 32'h0000000C, 8'h03}, 48'hA4A5A6A1A2A3,
              48'hB4B5B6B1B2B3, 48'h0};
        send(1, 144'hA1A2A3A4A5A6B1B2B3B4B5B6, 24'h00ABCD, 8'h12, 8'h03, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (pkt[1] !== w[k] || pv[1] !== 1'b1) begin
                errors++;
                $display("FAIL frame12_word%0d packet=%h pv=%b required %h pv=1", k, pkt[1], pv[1], w[k]);
            end
            @(negedge clk);
        end
        checks++;
        if (dr[1] !== 1'b1 || pv[1] !== 1'b0) begin
            errors++;
            $display("FAIL nogap_ready ready=%b pv=%b required ready=1 pv=0", dr[1], pv[1]);
        end
    endtask

    task automatic test_dlen8();
        logic [47:0] w [4];
        w = '{48'hEAFF99000001, 48'h2A0000000807, 48'h000102000000, 48'h060708030405};
        send(2, 144'h0102030405060708, 24'h000001, 8'h2A, 8'h07, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (pkt[2] !== w[k]) begin
                errors++;
                $display("FAIL frame8_word%0d packet=%h required %h", k, pkt[2], w[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        send(0, 144'h0000A0A0A0A0A0A0, 24'h000010, 8'h31, 8'h01, 1'b1);
        t0 = cyc;
        for (int k = 1; k < 4; k++) begin
            repeat (5) begin
                checks++;
                if (dr[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_busy_ready frame=%0d ready=%b required 0", k, dr[0]);
                end
                @(negedge clk);
            end
            send(0, {8'h00, 40'h0, {6{8'(k)}}}, 24'(16 + k), 8'h31, 8'h01, k < 3);
            checks++;
            if (cyc - t0 !== 6) begin
                errors++;
                $display("FAIL b2b_spacing frame=%0d cycles=%0d required 6", k, cyc - t0);
            end
            t0 = cyc;
        end
    endtask

    task automatic test_reset_mid();
        send(0, 144'hCAFEBABE0001, 24'h000055, 8'h11, 8'h01, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        q[0].delete();
        rq[0].delete();
        @(negedge clk);
        checks++;
        if (pkt[0] !== 48'h0 || pv[0] !== 1'b0 || tx[0] !== 1'b0 || dr[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid packet=%h pv=%b tx=%b ready=%b required all zero",
                     pkt[0], pv[0], tx[0], dr[0]);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dr[0] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_mid_reset ready=%b required 1", dr[0]);
        end
        send(0, 144'h0A0B0C0D0E0F, 24'h000066, 8'h22, 8'h02, 1'b0);
        checks++;
        if (pkt[0] !== {24'hEAFF99, 24'h000066}) begin
            errors++;
            $display("FAIL resend_sof packet=%h required eaff99000066", pkt[0]);
        end
    endtask

    task automatic test_random();
        logic [159:0] rd;
        int n;
        bit busy;
        send(0, 144'hEAFF99EAFF99, 24'hEAFF99, 8'hEA, 8'h99, 1'b0);
        for (int r = 0; r < 6; r++) begin
            for (int g = 0; g < NI; g++) begin
                rd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
                send(g, rd[143:0], 24'($urandom()), 8'($urandom()), 8'($urandom()), 1'b0);
            end
        end
        n = 0;
        busy = 1'b1;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
            busy = 1'b0;
            for (int g = 0; g < NI; g++) if (q[g].size() != 0 || rq[g].size() != 0) busy = 1'b1;
        end
        for (int g = 0; g < NI; g++) begin
            checks++;
            if (q[g].size() != 0 || rq[g].size() != 0) begin
                errors++;
                $display("FAIL drain inst=%0d words_left=%0d frames_left=%0d required 0",
                         g, q[g].size(), rq[g].size());
            end
        end
        repeat (10) @(negedge clk);
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            din[g] = '0;
            dv[g] = 1'b0;
            pid[g] = '0;
            dt[g] = '0;
            ph[g] = '0;
            rw[g] = 0;
            acc[g] = '0;
        end
        fork
            scoreboard();
        join_none
        test_reset();
        test_frame_dlen6();
        test_dlen12_nogap();
        test_dlen8();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
